iro_sweep_ctrl: RTL and testbench



---
 rtl/iro_sweep_ctrl.sv | 157 +++++++++++++++
 tb/tb_iro_sweep_ctrl.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/iro_sweep_ctrl.sv
// Sweep-and-capture controller for the instrumented ring oscillator: steps the stage count,
// restarts the ring per repetition, freezes it, snapshots the phase taps and streams records.
module iro_sweep_ctrl #(
  parameter int STAGE_BITS = 4,
  parameter int PHASE_W    = 16,
  parameter int SETTLE_W   = 8,
  parameter int REP_W      = 4,
  parameter int ONES_W     = $clog2(PHASE_W + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [STAGE_BITS-1:0] stage_min,
  input  logic [STAGE_BITS-1:0] stage_max,
  input  logic [SETTLE_W-1:0]   settle_cycles,
  input  logic [REP_W-1:0]      repeats,
  input  logic [PHASE_W-1:0]    iro_phases,
  output logic                  iro_enable,
  output logic                  iro_hold,
  output logic [STAGE_BITS-1:0] iro_n_stages,
  output logic                  busy,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [STAGE_BITS-1:0] res_stage,
  output logic [REP_W-1:0]      res_rep,
  output logic [PHASE_W-1:0]    res_phases,
  output logic [ONES_W-1:0]     res_ones,
  output logic                  done
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] KILL = 3'd1;
  localparam logic [2:0] RUN  = 3'd2;
  localparam logic [2:0] HOLD = 3'd3;
  localparam logic [2:0] CAPT = 3'd4;
  localparam logic [2:0] EMIT = 3'd5;
  localparam logic [2:0] FIN  = 3'd6;

  localparam int CNT_W = (SETTLE_W > 2) ? SETTLE_W : 2;

  logic [2:0]            state;
  logic [CNT_W-1:0]      cnt;
  logic [STAGE_BITS-1:0] stage;
  logic [STAGE_BITS-1:0] smax;
  logic [SETTLE_W-1:0]   settle;
  logic [REP_W-1:0]      reps;
  logic [REP_W-1:0]      rep;
  logic [PHASE_W-1:0]    sync1;
  logic [PHASE_W-1:0]    sync2;
  logic [ONES_W-1:0]     ones;

  // The synchronizer keeps clocking through abort so the taps are always fresh.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= iro_phases;
      sync2 <= sync1;
    end
  end

  always_comb begin
    ones = '0;
    for (int i = 0; i < PHASE_W; i++) begin
      ones = ones + ONES_W'(sync2[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst || abort) begin
      state        <= IDLE;
      cnt          <= '0;
      stage        <= '0;
      smax         <= '0;
      settle       <= '0;
      reps         <= '0;
      rep          <= '0;
      iro_n_stages <= '0;
      res_stage    <= '0;
      res_rep      <= '0;
      res_phases   <= '0;
      res_ones     <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            stage  <= stage_min;
            smax   <= stage_max;
            settle <= (settle_cycles == '0) ? SETTLE_W'(1) : settle_cycles;
            reps   <= (repeats == '0) ? REP_W'(1) : repeats;
            rep    <= '0;
            cnt    <= CNT_W'(1);
            state  <= (stage_min > stage_max) ? FIN : KILL;
          end
        end
        KILL: begin
          iro_n_stages <= stage;
          if (cnt == '0) begin
            cnt   <= CNT_W'(settle) - CNT_W'(1);
            state <= RUN;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        RUN: begin
          if (cnt == '0) begin
            cnt   <= CNT_W'(2);
            state <= HOLD;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        HOLD: begin
          if (cnt == '0) begin
            state <= CAPT;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        CAPT: begin
          res_phases <= sync2;
          res_ones   <= ones;
          res_stage  <= stage;
          res_rep    <= rep;
          state      <= EMIT;
        end
        EMIT: begin
          if (res_ready) begin
            cnt <= CNT_W'(1);
            // Compare before incrementing so a max-valued stage_max never wraps.
            if (rep < reps - REP_W'(1)) begin
              rep   <= rep + REP_W'(1);
              state <= KILL;
            end else if (stage < smax) begin
              stage <= stage + STAGE_BITS'(1);
              rep   <= '0;
              state <= KILL;
            end else begin
              state <= FIN;
            end
          end
        end
        FIN:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign iro_enable = (state == RUN) || (state == HOLD) || (state == CAPT) || (state == EMIT);
  assign iro_hold   = (state == HOLD) || (state == CAPT) || (state == EMIT);
  assign busy       = (state != IDLE);
  assign res_valid  = (state == EMIT);
  assign done       = (state == FIN);

endmodule

// File: tb/tb_iro_sweep_ctrl.sv
// Self-checking bench for iro_sweep_ctrl: a timing/record model derived from the sweep rules
// predicts every record, handshake spacing and the done pulse.
module tb_iro_sweep_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [3:0]  stage_min = '0;
  logic [3:0]  stage_max = '0;
  logic [7:0]  settle_cycles = '0;
  logic [3:0]  repeats = '0;
  logic [15:0] iro_phases = '0;
  logic        res_ready = 1'b1;
  logic        iro_enable, iro_hold, busy, res_valid, done;
  logic [3:0]  iro_n_stages, res_stage, res_rep;
  logic [15:0] res_phases;
  logic [4:0]  res_ones;
  logic [37:0] all_out;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  iro_sweep_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .abort        (abort),
    .stage_min    (stage_min),
    .stage_max    (stage_max),
    .settle_cycles(settle_cycles),
    .repeats      (repeats),
    .iro_phases   (iro_phases),
    .iro_enable   (iro_enable),
    .iro_hold     (iro_hold),
    .iro_n_stages (iro_n_stages),
    .busy         (busy),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_stage    (res_stage),
    .res_rep      (res_rep),
    .res_phases   (res_phases),
    .res_ones     (res_ones),
    .done         (done)
  );

  assign all_out = {iro_enable, iro_hold, iro_n_stages, busy, res_valid, res_stage, res_rep,
                    res_phases, res_ones, done};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // bp: 0 = ready always high, 1 = random ready, 2 = ready low for 20 cycles on record 0
  task automatic do_sweep(input int smin, input int smax, input int settle, input int reps,
                          input logic [15:0] ph, input int bp);
    int se, re, t0, e_at, done_at, n_rec;
    int q_stage[$];
    int q_rep[$];
    bit exp_valid, finished;
    se = (settle == 0) ? 1 : settle;
    re = (reps == 0) ? 1 : reps;
    for (int s = smin; s <= smax; s++)
      for (int r = 0; r < re; r++) begin
        q_stage.push_back(s);
        q_rep.push_back(r);
      end
    iro_phases = ph;
    res_ready = 1'b1;
    @(posedge clk); #1;
    stage_min = 4'(smin);
    stage_max = 4'(smax);
    settle_cycles = 8'(settle);
    repeats = 4'(reps);
    start = 1'b1;
    t0 = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    // Latched values must win over these later changes.
    stage_min = 4'($urandom);
    stage_max = 4'($urandom);
    settle_cycles = 8'($urandom);
    repeats = 4'($urandom);
    e_at = (q_stage.size() > 0) ? t0 + se + 7 : -1;
    done_at = (q_stage.size() > 0) ? -1 : t0 + 1;
    n_rec = 0;
    finished = 0;
    for (int k = 0; k < 6000; k++) begin
      if (bp == 0) res_ready = 1'b1;
      else if (bp == 1) res_ready = ($urandom_range(0, 2) != 0);
      else res_ready = !(n_rec == 0 && e_at >= 0 && cyc < e_at + 20);
      @(negedge clk);
      exp_valid = (q_stage.size() > 0) && (cyc >= e_at);
      total++;
      if (res_valid !== exp_valid) begin
        bad++;
        $display("FAIL valid cyc=%0d got=%b want=%b", cyc - t0, res_valid, exp_valid);
      end
      if (exp_valid) begin
        total++;
        if ({res_stage, res_rep, res_phases, res_ones, iro_enable, iro_hold} !==
            {4'(q_stage[0]), 4'(q_rep[0]), ph, 5'($countones(ph)), 2'b11}) begin
          bad++;
          $display("FAIL record cyc=%0d got st=%0d rep=%0d ph=%h ones=%0d en=%b hd=%b want st=%0d rep=%0d ph=%h ones=%0d en=1 hd=1",
                   cyc - t0, res_stage, res_rep, res_phases, res_ones, iro_enable, iro_hold,
                   q_stage[0], q_rep[0], ph, $countones(ph));
        end
      end
      if (q_stage.size() > 0 && cyc == e_at - 5) begin
        total++;
        if ({iro_enable, iro_hold, iro_n_stages} !== {2'b10, 4'(q_stage[0])}) begin
          bad++;
          $display("FAIL run_phase got en=%b hd=%b n=%0d want en=1 hd=0 n=%0d",
                   iro_enable, iro_hold, iro_n_stages, q_stage[0]);
        end
      end
      if (q_stage.size() > 0 && cyc == e_at - se - 6) begin
        total++;
        if ({iro_enable, iro_hold} !== 2'b00) begin
          bad++;
          $display("FAIL kill_phase got en=%b hd=%b want 0 0", iro_enable, iro_hold);
        end
      end
      total++;
      if ({done, busy} !== {(cyc == done_at), (done_at < 0 || cyc <= done_at)}) begin
        bad++;
        $display("FAIL done_busy cyc=%0d got done=%b busy=%b want done=%b busy=%b", cyc - t0,
                 done, busy, (cyc == done_at), (done_at < 0 || cyc <= done_at));
      end
      if (exp_valid && res_ready) begin
        void'(q_stage.pop_front());
        void'(q_rep.pop_front());
        n_rec++;
        if (q_stage.size() == 0) done_at = cyc + 1;
        else e_at = cyc + se + 7;
      end
      if (done_at >= 0 && cyc == done_at + 1) begin
        finished = 1;
        break;
      end
      @(posedge clk); #1;
    end
    if (!finished) begin
      total++;
      bad++;
      $display("FAIL sweep_timeout smin=%0d smax=%0d", smin, smax);
    end
    res_ready = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    total++;
    if (all_out !== '0) begin
      bad++;
      $display("FAIL reset_outputs got=%h want=0", all_out);
    end
  endtask

  task automatic test_basic();
    do_sweep(2, 4, 5, 1, 16'h1234, 0);
  endtask

  task automatic test_capture();
    do_sweep(3, 3, 4, 1, 16'hA5F0, 0);
    do_sweep(7, 8, 2, 1, 16'hFFFF, 0);
    do_sweep(1, 1, 3, 2, 16'h0000, 0);
  endtask

  task automatic test_backpressure();
    do_sweep(6, 7, 4, 1, 16'h0F0F, 2);
  endtask

  task automatic test_repeats_wrap();
    do_sweep(15, 15, 3, 3, 16'h8001, 0);
    do_sweep(5, 3, 6, 2, 16'h5555, 0);
  endtask

  task automatic test_zero_fields();
    do_sweep(9, 10, 0, 0, 16'h00FF, 0);
  endtask

  task automatic test_abort_reset();
    int t0;
    // abort in RUN, with a simultaneous start that must be ignored
    @(posedge clk); #1;
    stage_min = 4'd2; stage_max = 4'd6; settle_cycles = 8'd10; repeats = 4'd1;
    start = 1'b1;
    t0 = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    abort = 1'b1;
    start = 1'b1;
    @(negedge clk);
    total++;
    if ({busy, iro_enable, iro_hold} !== 3'b110) begin
      bad++;
      $display("FAIL abort_in_run got busy=%b en=%b hd=%b want 1 1 0", busy, iro_enable, iro_hold);
    end
    @(posedge clk); #1;
    abort = 1'b0;
    start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      total++;
      if (all_out !== '0) begin
        bad++;
        $display("FAIL abort_idle i=%0d got=%h want=0", i, all_out);
      end
    end
    // reset while a record is waiting in EMIT
    @(posedge clk); #1;
    stage_min = 4'd4; stage_max = 4'd5; settle_cycles = 8'd3; repeats = 4'd1;
    res_ready = 1'b0;
    start = 1'b1;
    t0 = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    while (cyc < t0 + 12) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (res_valid !== 1'b1) begin
      bad++;
      $display("FAIL emit_before_rst got=%b want=1", res_valid);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    res_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      total++;
      if (all_out !== '0) begin
        bad++;
        $display("FAIL rst_idle i=%0d got=%h want=0", i, all_out);
      end
    end
    do_sweep(0, 1, 2, 2, 16'hC3C3, 0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 8; n++) begin
      int a, b;
      a = $urandom_range(0, 15);
      b = $urandom_range(a, (a + 2 > 15) ? 15 : a + 2);
      do_sweep(a, b, $urandom_range(0, 6), $urandom_range(0, 3), 16'($urandom), 1);
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    test_reset();
    test_basic();
    test_capture();
    test_backpressure();
    test_repeats_wrap();
    test_zero_fields();
    test_abort_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
